// File: rtl/gtx_link_supervisor.sv
// GTX receiver bring-up supervisor: sequences PLL lock, RX reset, byte alignment and a
// stability window, and re-runs the sequence on loss of alignment or on request.
module gtx_link_supervisor #(
    parameter int unsigned RESET_PULSE_CYCLES = 16,
    parameter int unsigned ALIGN_TIMEOUT      = 65535,
    parameter int unsigned STABLE_CYCLES      = 1024
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       gt_pll_locked,
    input  logic       byteisaligned,
    input  logic       force_resync,
    output logic       gt_rx_reset,
    output logic       link_up,
    output logic [2:0] state,
    output logic [7:0] retry_count
);

    typedef enum logic [2:0] {
        StWaitPll   = 3'd0,
        StRxReset   = 3'd1,
        StWaitAlign = 3'd2,
        StStabilize = 3'd3,
        StLinkUp    = 3'd4
    } state_e;

    localparam int unsigned MaxAB    = (RESET_PULSE_CYCLES > ALIGN_TIMEOUT) ?
                                       RESET_PULSE_CYCLES : ALIGN_TIMEOUT;
    localparam int unsigned TimerMax = (MaxAB > STABLE_CYCLES) ? MaxAB : STABLE_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    typedef logic [TimerW-1:0] timer_t;

    localparam timer_t RstLast    = timer_t'(RESET_PULSE_CYCLES - 1);
    localparam timer_t AlignLast  = timer_t'(ALIGN_TIMEOUT - 1);
    localparam timer_t StableLast = timer_t'(STABLE_CYCLES - 1);
    localparam timer_t TimerSat   = timer_t'(TimerMax);

    state_e     state_q, state_d;
    timer_t     timer_q, timer_d;
    logic [7:0] retry_q, retry_d;
    logic       reload;
    logic       retry_inc;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q <= StWaitPll;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        reload    = 1'b0;
        retry_inc = 1'b0;
        // PLL loss dominates, then an explicit resync, then the normal sequence.
        if (state_q != StWaitPll && !gt_pll_locked) begin
            state_d = StWaitPll;
        end else if (force_resync &&
                     (state_q inside {StRxReset, StWaitAlign, StStabilize, StLinkUp})) begin
            state_d = StRxReset;
            reload  = 1'b1;
        end else begin
            case (state_q)
                StWaitPll: begin
                    if (gt_pll_locked) state_d = StRxReset;
                end
                StRxReset: begin
                    if (timer_q == RstLast) state_d = StWaitAlign;
                end
                StWaitAlign: begin
                    if (byteisaligned) begin
                        state_d = StStabilize;
                    end else if (timer_q == AlignLast) begin
                        state_d   = StRxReset;
                        retry_inc = 1'b1;
                    end
                end
                StStabilize: begin
                    if (!byteisaligned) begin
                        state_d   = StRxReset;
                        retry_inc = 1'b1;
                    end else if (timer_q == StableLast) begin
                        state_d = StLinkUp;
                    end
                end
                StLinkUp: begin
                    if (!byteisaligned) begin
                        state_d   = StRxReset;
                        retry_inc = 1'b1;
                    end
                end
                default: state_d = StWaitPll;
            endcase
        end

        // Timer counts cycles spent in the current state and holds at its ceiling.
        if (reload || (state_d != state_q)) begin
            timer_d = '0;
        end else if (timer_q == TimerSat) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (retry_inc && (retry_q != 8'hff)) begin
            retry_d = retry_q + 8'd1;
        end else begin
            retry_d = retry_q;
        end
    end

    always_comb begin
        gt_rx_reset = (state_q == StWaitPll) || (state_q == StRxReset);
        link_up     = (state_q == StLinkUp);
        state       = state_q;
        retry_count = retry_q;
    end

endmodule

// File: tb/tb_gtx_link_supervisor.sv
// Scenario bench for gtx_link_supervisor: each task queues per-cycle stimulus with the
// expected post-edge state and retry count, then drains the queue against the DUT.
module tb_gtx_link_supervisor;

    logic       ref_clk = 1'b0;
    logic       reset = 1'b1;
    logic       gt_pll_locked = 1'b0;
    logic       byteisaligned = 1'b0;
    logic       force_resync = 1'b0;
    logic       gt_rx_reset;
    logic       link_up;
    logic [2:0] state;
    logic [7:0] retry_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       rst;
        logic       pll;
        logic       al;
        logic       rs;
        logic [2:0] st;
        logic [7:0] rc;
    } vec_t;

    vec_t sbq[$];

    gtx_link_supervisor #(
        .RESET_PULSE_CYCLES(4),
        .ALIGN_TIMEOUT     (20),
        .STABLE_CYCLES     (8)
    ) dut (
        .ref_clk      (ref_clk),
        .reset        (reset),
        .gt_pll_locked(gt_pll_locked),
        .byteisaligned(byteisaligned),
        .force_resync (force_resync),
        .gt_rx_reset  (gt_rx_reset),
        .link_up      (link_up),
        .state        (state),
        .retry_count  (retry_count)
    );

    always #5 ref_clk = ~ref_clk;

    function automatic void push(logic rst, logic pll, logic al, logic rs,
                                 logic [2:0] st, logic [7:0] rc);
        vec_t v;
        v.rst = rst; v.pll = pll; v.al = al; v.rs = rs; v.st = st; v.rc = rc;
        sbq.push_back(v);
    endfunction

    // From RX_RESET (rx_left samples still to see) through alignment to LINK_UP.
    function automatic void push_rx_to_link(int rx_left, logic [7:0] rc);
        for (int i = 0; i < rx_left; i++) push(0, 1, 0, 0, 3'd1, rc);
        push(0, 1, 0, 0, 3'd2, rc);
        for (int i = 0; i < 8; i++) push(0, 1, 1, 0, 3'd3, rc);
        push(0, 1, 1, 0, 3'd4, rc);
    endfunction

    function automatic logic exp_rx(logic [2:0] st);
        return (st == 3'd0) || (st == 3'd1);
    endfunction

    task automatic test_reset();
        vec_t v;
        int   cyc = 0;
        for (int i = 0; i < 5; i++)
            push(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'd0, 8'd0);
        // Resync and alignment must not move the FSM out of WAIT_PLL.
        for (int i = 0; i < 3; i++) push(0, 0, 1, 1, 3'd0, 8'd0);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            reset = v.rst; gt_pll_locked = v.pll; byteisaligned = v.al; force_resync = v.rs;
            @(posedge ref_clk); #1;
            total++; cyc++;
            if (state !== v.st || retry_count !== v.rc || gt_rx_reset !== exp_rx(v.st) ||
                link_up !== (v.st == 3'd4)) begin
                bad++;
                $display("FAIL reset cyc%0d: got st=%0d rx=%b up=%b rc=%0d want st=%0d rx=%b up=%b rc=%0d",
                         cyc, state, gt_rx_reset, link_up, retry_count, v.st, exp_rx(v.st),
                         v.st == 3'd4, v.rc);
            end
        end
    endtask

    task automatic test_bringup();
        vec_t v;
        int   cyc = 0;
        push(1, 0, 0, 0, 3'd0, 8'd0);
        push_rx_to_link(4, 8'd0);
        for (int i = 0; i < 3; i++) push(0, 1, 1, 0, 3'd4, 8'd0);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            reset = v.rst; gt_pll_locked = v.pll; byteisaligned = v.al; force_resync = v.rs;
            @(posedge ref_clk); #1;
            total++; cyc++;
            if (state !== v.st || retry_count !== v.rc || gt_rx_reset !== exp_rx(v.st) ||
                link_up !== (v.st == 3'd4)) begin
                bad++;
                $display("FAIL bringup cyc%0d: got st=%0d rx=%b up=%b rc=%0d want st=%0d rx=%b up=%b rc=%0d",
                         cyc, state, gt_rx_reset, link_up, retry_count, v.st, exp_rx(v.st),
                         v.st == 3'd4, v.rc);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t       v;
        int         cyc = 0;
        logic [7:0] rc;
        push(1, 0, 0, 0, 3'd0, 8'd0);
        for (int k = 0; k < 300; k++) begin
            rc = (k > 255) ? 8'd255 : 8'(k);
            for (int i = 0; i < 4; i++) push(0, 1, 0, 0, 3'd1, rc);
            for (int i = 0; i < 20; i++) push(0, 1, 0, 0, 3'd2, rc);
        end
        push(0, 1, 0, 0, 3'd1, 8'd255);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            reset = v.rst; gt_pll_locked = v.pll; byteisaligned = v.al; force_resync = v.rs;
            @(posedge ref_clk); #1;
            total++; cyc++;
            if (state !== v.st || retry_count !== v.rc || gt_rx_reset !== exp_rx(v.st) ||
                link_up !== (v.st == 3'd4)) begin
                bad++;
                $display("FAIL timeout cyc%0d: got st=%0d rx=%b up=%b rc=%0d want st=%0d rx=%b up=%b rc=%0d",
                         cyc, state, gt_rx_reset, link_up, retry_count, v.st, exp_rx(v.st),
                         v.st == 3'd4, v.rc);
            end
        end
    endtask

    task automatic test_glitch();
        vec_t v;
        int   cyc = 0;
        push(1, 0, 0, 0, 3'd0, 8'd0);
        for (int i = 0; i < 4; i++) push(0, 1, 0, 0, 3'd1, 8'd0);
        push(0, 1, 0, 0, 3'd2, 8'd0);
        for (int i = 0; i < 5; i++) push(0, 1, 1, 0, 3'd3, 8'd0);
        push(0, 1, 0, 0, 3'd1, 8'd1);
        for (int i = 0; i < 3; i++) push(0, 1, 1, 0, 3'd1, 8'd1);
        push(0, 1, 1, 0, 3'd2, 8'd1);
        push(0, 1, 1, 0, 3'd3, 8'd1);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            reset = v.rst; gt_pll_locked = v.pll; byteisaligned = v.al; force_resync = v.rs;
            @(posedge ref_clk); #1;
            total++; cyc++;
            if (state !== v.st || retry_count !== v.rc || gt_rx_reset !== exp_rx(v.st) ||
                link_up !== (v.st == 3'd4)) begin
                bad++;
                $display("FAIL glitch cyc%0d: got st=%0d rx=%b up=%b rc=%0d want st=%0d rx=%b up=%b rc=%0d",
                         cyc, state, gt_rx_reset, link_up, retry_count, v.st, exp_rx(v.st),
                         v.st == 3'd4, v.rc);
            end
        end
    endtask

    task automatic test_link_loss();
        vec_t v;
        int   cyc = 0;
        push(1, 0, 0, 0, 3'd0, 8'd0);
        push_rx_to_link(4, 8'd0);
        push(0, 1, 0, 0, 3'd1, 8'd1);
        push_rx_to_link(3, 8'd1);
        push(0, 0, 1, 0, 3'd0, 8'd1);
        push(0, 0, 1, 0, 3'd0, 8'd1);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            reset = v.rst; gt_pll_locked = v.pll; byteisaligned = v.al; force_resync = v.rs;
            @(posedge ref_clk); #1;
            total++; cyc++;
            if (state !== v.st || retry_count !== v.rc || gt_rx_reset !== exp_rx(v.st) ||
                link_up !== (v.st == 3'd4)) begin
                bad++;
                $display("FAIL link_loss cyc%0d: got st=%0d rx=%b up=%b rc=%0d want st=%0d rx=%b up=%b rc=%0d",
                         cyc, state, gt_rx_reset, link_up, retry_count, v.st, exp_rx(v.st),
                         v.st == 3'd4, v.rc);
            end
        end
    endtask

    task automatic test_simultaneous();
        vec_t v;
        int   cyc = 0;
        push(1, 0, 0, 0, 3'd0, 8'd0);
        push_rx_to_link(4, 8'd0);
        push(0, 0, 1, 1, 3'd0, 8'd0);
        push_rx_to_link(4, 8'd0);
        push(0, 1, 1, 1, 3'd1, 8'd0);
        push(0, 1, 1, 0, 3'd1, 8'd0);
        // Resync inside RX_RESET restarts the pulse count.
        push(0, 1, 1, 1, 3'd1, 8'd0);
        for (int i = 0; i < 3; i++) push(0, 1, 0, 0, 3'd1, 8'd0);
        push(0, 1, 0, 0, 3'd2, 8'd0);
        push(0, 1, 1, 0, 3'd3, 8'd0);
        push(0, 1, 1, 1, 3'd1, 8'd0);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            reset = v.rst; gt_pll_locked = v.pll; byteisaligned = v.al; force_resync = v.rs;
            @(posedge ref_clk); #1;
            total++; cyc++;
            if (state !== v.st || retry_count !== v.rc || gt_rx_reset !== exp_rx(v.st) ||
                link_up !== (v.st == 3'd4)) begin
                bad++;
                $display("FAIL simultaneous cyc%0d: got st=%0d rx=%b up=%b rc=%0d want st=%0d rx=%b up=%b rc=%0d",
                         cyc, state, gt_rx_reset, link_up, retry_count, v.st, exp_rx(v.st),
                         v.st == 3'd4, v.rc);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t v;
        int   cyc = 0;
        push(1, 0, 0, 0, 3'd0, 8'd0);
        for (int i = 0; i < 4; i++) push(0, 1, 0, 0, 3'd1, 8'd0);
        for (int g = 0; g < 3; g++) begin
            if (g != 0)
                for (int i = 0; i < 3; i++) push(0, 1, 0, 0, 3'd1, 8'(g));
            push(0, 1, 0, 0, 3'd2, 8'(g));
            push(0, 1, 1, 0, 3'd3, 8'(g));
            push(0, 1, 0, 0, 3'd1, 8'(g + 1));
        end
        for (int i = 0; i < 3; i++) push(0, 1, 0, 0, 3'd1, 8'd3);
        push(0, 1, 0, 0, 3'd2, 8'd3);
        push(0, 1, 1, 0, 3'd3, 8'd3);
        push(0, 1, 1, 0, 3'd3, 8'd3);
        push(1, 1, 1, 0, 3'd0, 8'd0);
        push(1, 1, 1, 1, 3'd0, 8'd0);
        push(0, 1, 1, 0, 3'd1, 8'd0);
        while (sbq.size() != 0) begin
            v = sbq.pop_front();
            reset = v.rst; gt_pll_locked = v.pll; byteisaligned = v.al; force_resync = v.rs;
            @(posedge ref_clk); #1;
            total++; cyc++;
            if (state !== v.st || retry_count !== v.rc || gt_rx_reset !== exp_rx(v.st) ||
                link_up !== (v.st == 3'd4)) begin
                bad++;
                $display("FAIL reset_mid cyc%0d: got st=%0d rx=%b up=%b rc=%0d want st=%0d rx=%b up=%b rc=%0d",
                         cyc, state, gt_rx_reset, link_up, retry_count, v.st, exp_rx(v.st),
                         v.st == 3'd4, v.rc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout();
        test_glitch();
        test_link_loss();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
